// File: rtl/stream_max_tracker_if.sv
// Handshake bundle for stream_max_tracker: sample stream in, frame summary out.
// master = producer/consumer side, slave = tracker.
interface stream_max_tracker_if #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [IDX_W-1:0] out_idx;
  logic [IDX_W:0]   out_len;
  logic             out_trunc;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_idx, out_len, out_trunc
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max, out_idx, out_len, out_trunc
  );
endinterface

// File: rtl/stream_max_tracker.sv
// Tracks the running maximum of a framed sample stream and holds the frame
// summary (max, first index of max, length, truncation flag) until taken.
module stream_max_tracker #(
  parameter int WIDTH   = 4,
  parameter int MAX_LEN = 16,
  parameter int IDX_W   = 4
) (
  input logic             clk,
  input logic             rst,
  stream_max_tracker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [IDX_W:0] ONE     = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(MAX_LEN);

  state_t           state;
  logic [WIDTH-1:0] run_max;
  logic [IDX_W-1:0] run_idx;
  logic [IDX_W:0]   len;
  logic [WIDTH-1:0] max_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W:0]   len_q;
  logic             trunc_q;

  logic             accept;
  logic             close;
  logic [WIDTH-1:0] acc_max;
  logic [IDX_W-1:0] acc_idx;
  logic [IDX_W:0]   acc_len;

  assign accept = bus.in_valid && (state != DONE);

  // Running values including the sample on this edge; the IDLE case yields
  // len 1, so the MAX_LEN==1 close falls out of the same length compare.
  always_comb begin
    acc_max = bus.in_data;
    acc_idx = '0;
    acc_len = ONE;
    if (state == ACC) begin
      if (bus.in_data > run_max) begin
        acc_max = bus.in_data;
        acc_idx = len[IDX_W-1:0];
      end else begin
        acc_max = run_max;
        acc_idx = run_idx;
      end
      acc_len = len + ONE;
    end
    close = bus.in_last || (acc_len == LEN_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      run_max <= '0;
      run_idx <= '0;
      len     <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) begin
            run_max <= acc_max;
            run_idx <= acc_idx;
            len     <= acc_len;
            if (close) begin
              state   <= DONE;
              max_q   <= acc_max;
              idx_q   <= acc_idx;
              len_q   <= acc_len;
              trunc_q <= !bus.in_last;
            end else begin
              state <= ACC;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state != DONE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_max   = max_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_len   = len_q;
  assign bus.out_trunc = trunc_q;

endmodule

// File: tb/tb_stream_max_tracker.sv
// Bench for stream_max_tracker: frame-level reference model checked every
// cycle, directed frames with literal expectations, then randomized traffic.
module tb_stream_max_tracker;
  localparam int WIDTH   = 4;
  localparam int MAX_LEN = 16;
  localparam int IDX_W   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_max_tracker_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bif ();

  stream_max_tracker #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .IDX_W(IDX_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  int checks = 0;
  int errors = 0;
  bit rand_ready = 1'b0;

  // Reference: collect the frame's samples, summarise when it closes.
  int m_q[$];
  bit m_hold = 1'b0;
  int m_max, m_idx, m_len;
  bit m_trunc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_hold = 1'b0;
    end else if (m_hold) begin
      if (bif.out_ready) m_hold = 1'b0;
    end else if (bif.in_valid) begin
      m_q.push_back(int'(bif.in_data));
      if (bif.in_last || m_q.size() == MAX_LEN) begin
        m_max = 0;
        foreach (m_q[i]) if (m_q[i] > m_max) m_max = m_q[i];
        m_idx = 0;
        for (int i = m_q.size() - 1; i >= 0; i--) if (m_q[i] == m_max) m_idx = i;
        m_len   = m_q.size();
        m_trunc = !bif.in_last;
        m_hold  = 1'b1;
        m_q.delete();
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", int'(bif.in_ready), int'(!m_hold));
      chk("out_valid", int'(bif.out_valid), int'(m_hold));
      if (m_hold && bif.out_valid) begin
        chk("model_max", int'(bif.out_max), m_max);
        chk("model_idx", int'(bif.out_idx), m_idx);
        chk("model_len", int'(bif.out_len), m_len);
        chk("model_trunc", int'(bif.out_trunc), int'(m_trunc));
      end
    end
  end

  task automatic send(int d, bit last);
    bit r;
    bit done;
    done = 1'b0;
    bif.in_valid = 1'b1;
    bif.in_data  = d[WIDTH-1:0];
    bif.in_last  = last;
    for (int c = 0; c < 400 && !done; c++) begin
      if (rand_ready) bif.out_ready = 1'($urandom_range(0, 1));
      r = bif.in_ready;
      @(negedge clk);
      if (r) done = 1'b1;
    end
    bif.in_valid = 1'b0;
    bif.in_last  = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_valid(string name);
    int c;
    c = 0;
    while (!bif.out_valid && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (!bif.out_valid) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic chk_res(string p, int mx, int idx, int len, int tr);
    chk({p, "_max"},   int'(bif.out_max),   mx);
    chk({p, "_idx"},   int'(bif.out_idx),   idx);
    chk({p, "_len"},   int'(bif.out_len),   len);
    chk({p, "_trunc"}, int'(bif.out_trunc), tr);
  endtask

  task automatic take();
    bif.out_ready = 1'b1;
    @(negedge clk);
    bif.out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bif.in_valid  = 1'b0;
    bif.in_data   = '0;
    bif.in_last   = 1'b0;
    bif.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(bif.in_ready), 1);
    chk("rst_out_valid", int'(bif.out_valid), 0);
    chk_res("rst", 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);

    // basic frame, consumer always ready
    bif.out_ready = 1'b1;
    send(11, 0); send(10, 0); send(9, 0); send(0, 1);
    bif.out_ready = 1'b0;
    chk("t1_latency", int'(bif.out_valid), 1);
    chk_res("t1", 11, 0, 4, 0);
    take();

    // ties keep earliest index, with bubbles
    send(5, 0); repeat (2) @(negedge clk);
    send(12, 0); @(negedge clk);
    send(12, 0); repeat (3) @(negedge clk);
    send(2, 1);
    wait_valid("t2");
    chk_res("t2", 12, 1, 4, 0);
    take();

    // single-sample frames, no carry-over
    send(9, 1);
    wait_valid("t3a");
    chk_res("t3a", 9, 0, 1, 0);
    take();
    send(3, 1);
    wait_valid("t3b");
    chk_res("t3b", 3, 0, 1, 0);
    take();

    // truncation at MAX_LEN, 17th sample stalls
    for (int i = 0; i < 16; i++) send(i, 0);
    wait_valid("t4");
    chk_res("t4", 15, 15, 16, 1);
    bif.in_valid = 1'b1;
    bif.in_data  = '0;
    bif.in_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t4_stall", int'(bif.in_ready), 0);
    end
    bif.out_ready = 1'b1;
    send(0, 1);
    bif.out_ready = 1'b0;
    chk_res("t4_next", 0, 0, 1, 0);
    take();

    // in_last on the MAX_LEN-th sample is not a truncation
    for (int i = 0; i < 16; i++) send((i * 7) % 16, i == 15);
    wait_valid("t4b");
    chk_res("t4b", 15, 9, 16, 0);
    take();

    // backpressure
    send(4, 0); send(13, 1);
    wait_valid("t5");
    chk_res("t5", 13, 1, 2, 0);
    bif.in_valid = 1'b1;
    bif.in_data  = 4'd6;
    repeat (5) begin
      @(negedge clk);
      chk("t5_ready", int'(bif.in_ready), 0);
      chk_res("t5_hold", 13, 1, 2, 0);
    end
    bif.out_ready = 1'b1;
    @(negedge clk);
    bif.out_ready = 1'b0;
    chk("t5_drop_valid", int'(bif.out_valid), 0);
    chk("t5_rise_ready", int'(bif.in_ready), 1);
    send(6, 1);
    wait_valid("t5b");
    chk_res("t5b", 6, 0, 1, 0);
    take();

    // asynchronous reset mid-frame
    send(7, 0); send(14, 0);
    #2 rst = 1'b1;
    #1;
    chk("t6_in_ready", int'(bif.in_ready), 1);
    chk("t6_out_valid", int'(bif.out_valid), 0);
    chk_res("t6_rst", 0, 0, 0, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    send(1, 1);
    wait_valid("t6");
    chk_res("t6", 1, 0, 1, 0);
    take();

    // randomized traffic with random backpressure
    rand_ready = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) begin
        bif.out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      send(int'($urandom_range(0, 15)), $urandom_range(0, 5) == 0);
    end
    rand_ready = 1'b0;
    bif.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    bif.out_ready = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
